// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with req/ack instruction and data memory ports.
// Define HACK_CPU_PERF_EN to add the 32-bit retired-instruction counter.
module hack_cpu_mc #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        dbg_state
`ifdef HACK_CPU_PERF_EN
  ,
  output logic [31:0]       retired
`endif
);

  // Handshake: a request is held (with stable addr/we/wdata) until ack is sampled
  // high on a rising edge; req drops on that edge and ack is ignored while req=0.
  typedef enum logic [1:0] {FETCH, MREAD, EXEC, MWRITE} state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  state_t              state;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   a_reg;
  logic [DATA_W-1:0]   d_reg;
  logic [DATA_W-1:0]   m_reg;
  logic                jump_q;
  logic [DATA_W-1:0]   alu_x;
  logic [DATA_W-1:0]   alu_y;
  logic [DATA_W-1:0]   alu_out;
  logic                zr;
  logic                ng;
  logic                taken;
  logic [ADDR_W-1:0]   pc_inc;

  assign dbg_state = state;
  assign imem_addr = pc;
  assign pc_inc    = pc + PC_ONE;

  always_comb begin
    alu_x = ir[11] ? '0 : d_reg;
    if (ir[10]) alu_x = ~alu_x;
    alu_y = ir[12] ? m_reg : a_reg;
    if (ir[9]) alu_y = '0;
    if (ir[8]) alu_y = ~alu_y;
    alu_out = ir[7] ? (alu_x + alu_y) : (alu_x & alu_y);
    if (ir[6]) alu_out = ~alu_out;
  end

  assign zr    = (alu_out == '0);
  assign ng    = alu_out[DATA_W-1];
  assign taken = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~zr & ~ng);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FETCH;
      ir         <= '0;
      a_reg      <= '0;
      d_reg      <= '0;
      m_reg      <= '0;
      pc         <= '0;
      jump_q     <= 1'b0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            imem_req <= 1'b0;
            ir       <= imem_rdata;
            // A is still the instruction-start value here, so it is the M address.
            if (imem_rdata[DATA_W-1] && imem_rdata[12]) begin
              state     <= MREAD;
              dmem_req  <= 1'b1;
              dmem_we   <= 1'b0;
              dmem_addr <= a_reg[ADDR_W-1:0];
            end else begin
              state <= EXEC;
            end
          end
        end
        MREAD: begin
          if (dmem_ack) begin
            m_reg    <= dmem_rdata;
            dmem_req <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (!ir[DATA_W-1]) begin
            a_reg    <= {1'b0, ir[DATA_W-2:0]};
            pc       <= pc_inc;
            state    <= FETCH;
            imem_req <= 1'b1;
          end else begin
            if (ir[4]) d_reg <= alu_out;
            if (ir[5]) a_reg <= alu_out;
            if (ir[3]) begin
              // dmem_addr keeps old A and doubles as the jump target in MWRITE.
              state      <= MWRITE;
              dmem_req   <= 1'b1;
              dmem_we    <= 1'b1;
              dmem_addr  <= a_reg[ADDR_W-1:0];
              dmem_wdata <= alu_out;
              jump_q     <= taken;
            end else begin
              pc       <= taken ? a_reg[ADDR_W-1:0] : pc_inc;
              state    <= FETCH;
              imem_req <= 1'b1;
            end
          end
        end
        MWRITE: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            pc       <= jump_q ? dmem_addr : pc_inc;
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef HACK_CPU_PERF_EN
  logic done;

  assign done = ((state == EXEC) && !(ir[DATA_W-1] && ir[3])) ||
                ((state == MWRITE) && dmem_ack);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired <= '0;
    end else if (done) begin
      retired <= retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Scoreboard bench for hack_cpu_mc: directed program, memory responder and monitor.
module tb_hack_cpu_mc;
  localparam int DW = 16;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic [AW-1:0] pc;
  logic [1:0]    dbg_state;
`ifdef HACK_CPU_PERF_EN
  logic [31:0]   retired;
`endif

  // clock / reset
  always #5 clk = ~clk;

  hack_cpu_mc #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .pc(pc),
    .dbg_state(dbg_state)
`ifdef HACK_CPU_PERF_EN
    ,
    .retired(retired)
`endif
  );

  // fetch_q entry: {addr[14:0], gap[15:0]} (gap 16'hFFFF = not checked)
  // exp_q entry:   {we, addr[14:0], data[15:0], waits[7:0]}
  logic [30:0]   fetch_q[$];
  logic [39:0]   exp_q[$];
  logic [15:0]   imem [0:32767];

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            last_fetch_cyc = 0;
  int            dm_cnt = 0;
  int            wait_n;
  logic          dm_busy = 1'b0;
  logic          dm_prev_ack = 1'b0;
  logic          stray_ack = 1'b0;
  logic          cap_we;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic [39:0]   e;
  logic [30:0]   f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_fetch(input logic [14:0] addr, input logic [15:0] gap);
    fetch_q.push_back({addr, gap});
  endtask

  task automatic push_dm(input logic we, input logic [14:0] addr, input logic [15:0] data,
                         input logic [7:0] waits);
    exp_q.push_back({we, addr, data, waits});
  endtask

  // memory responder + monitor: pops expectations whenever the DUT completes a transfer
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      dm_busy = 1'b0;
      dm_prev_ack = 1'b0;
    end
    if (dm_prev_ack) check("dmem_req_drop", 32'(dmem_req), 32'd0);
    dm_prev_ack = 1'b0;

    imem_ack = 1'b0;
    if (imem_req === 1'b1) begin
      imem_ack = 1'b1;
      imem_rdata = imem[imem_addr];
      if (fetch_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_fetch: got addr %0h expected none", imem_addr);
      end else begin
        f = fetch_q.pop_front();
        check("fetch_addr", 32'(imem_addr), 32'(f[30:16]));
        check("fetch_pc", 32'(pc), 32'(f[30:16]));
        if (f[15:0] != 16'hFFFF) check("fetch_gap", 32'(cyc - last_fetch_cyc), 32'(f[15:0]));
      end
      last_fetch_cyc = cyc;
    end

    dmem_ack = stray_ack;
    if (dmem_req === 1'b1 && exp_q.size() != 0) begin
      e = exp_q[0];
      if (!dm_busy) begin
        dm_busy = 1'b1;
        dm_cnt = 0;
        cap_we = dmem_we;
        cap_addr = dmem_addr;
        cap_wdata = dmem_wdata;
      end else begin
        check("hold_we", 32'(dmem_we), 32'(cap_we));
        check("hold_addr", 32'(dmem_addr), 32'(cap_addr));
        check("hold_wdata", 32'(dmem_wdata), 32'(cap_wdata));
      end
      if (dm_cnt == int'(e[7:0])) begin
        void'(exp_q.pop_front());
        dmem_ack = 1'b1;
        dm_busy = 1'b0;
        dm_prev_ack = 1'b1;
        check("dmem_we", 32'(dmem_we), 32'(e[39]));
        check("dmem_addr", 32'(dmem_addr), 32'(e[38:24]));
        if (e[39]) check("dmem_wdata", 32'(dmem_wdata), 32'(e[23:8]));
        else dmem_rdata = e[23:8];
      end else begin
        dm_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    imem_rdata = '0;
    dmem_rdata = '0;
    for (int i = 0; i < 32768; i++) imem[i] = 16'h0000;
    imem[0]  = 16'h0005;  // @5
    imem[1]  = 16'hEC10;  // D=A
    imem[2]  = 16'h0064;  // @100
    imem[3]  = 16'hE308;  // M=D
    imem[4]  = 16'hFC10;  // D=M
    imem[5]  = 16'hE308;  // M=D
    imem[6]  = 16'h0007;  // @7
    imem[7]  = 16'hEC10;  // D=A
    imem[8]  = 16'h0064;  // @100
    imem[9]  = 16'hE7C8;  // M=D+1
    imem[10] = 16'hFDE8;  // AM=M+1
    imem[11] = 16'hEC10;  // D=A
    imem[12] = 16'h0065;  // @101
    imem[13] = 16'hE308;  // M=D
    imem[14] = 16'hEE90;  // D=-1
    imem[15] = 16'h002A;  // @42
    imem[16] = 16'hE304;  // D;JLT
    imem[42] = 16'hE301;  // D;JGT
    imem[43] = 16'h7FFF;  // @0x7FFF
    imem[44] = 16'hEA87;  // 0;JMP
    imem[32767] = 16'hE7D2;  // D=D+1;JEQ (taken once with D=-1, then falls through)

    repeat (3) @(negedge clk);
    #1;
    check("reset_pc", 32'(pc), 32'd0);
    check("reset_imem_req", 32'(imem_req), 32'd0);
    check("reset_dmem_req", 32'(dmem_req), 32'd0);

    push_fetch(15'd0, 16'hFFFF);
    push_fetch(15'd1, 16'd2);
    push_fetch(15'd2, 16'd2);
    push_fetch(15'd3, 16'd2);
    push_fetch(15'd4, 16'd3);   push_dm(1'b1, 15'd100, 16'h0005, 8'd0);
    push_fetch(15'd5, 16'd5);   push_dm(1'b0, 15'd100, 16'h1234, 8'd2);
    push_fetch(15'd6, 16'd3);   push_dm(1'b1, 15'd100, 16'h1234, 8'd0);
    push_fetch(15'd7, 16'd2);
    push_fetch(15'd8, 16'd2);
    push_fetch(15'd9, 16'd2);
    push_fetch(15'd10, 16'd6);  push_dm(1'b1, 15'd100, 16'h0008, 8'd3);
    push_fetch(15'd11, 16'd4);  push_dm(1'b0, 15'd100, 16'h0008, 8'd0);
                                push_dm(1'b1, 15'd100, 16'h0009, 8'd0);
    push_fetch(15'd12, 16'd2);
    push_fetch(15'd13, 16'd2);
    push_fetch(15'd14, 16'd3);  push_dm(1'b1, 15'd101, 16'h0009, 8'd0);
    push_fetch(15'd15, 16'd2);
    push_fetch(15'd16, 16'd2);
    push_fetch(15'd42, 16'd2);
    push_fetch(15'd43, 16'd2);
    push_fetch(15'd44, 16'd2);
    push_fetch(15'h7FFF, 16'd2);
    push_fetch(15'h7FFF, 16'd2);
    push_fetch(15'd0, 16'd2);
    push_fetch(15'd1, 16'd2);
    push_fetch(15'd2, 16'd2);
    push_fetch(15'd3, 16'd2);

    reset = 1'b1;
    @(negedge clk);
    #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", 32'(imem_addr), 32'd0);

    wait_n = 0;
    while (fetch_q.size() != 0 && wait_n < 600) begin
      @(negedge clk);
      #1;
      wait_n++;
    end
    check("program_fetches_left", 32'(fetch_q.size()), 32'd0);

    wait_n = 0;
    while (dmem_req !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      #1;
      wait_n++;
    end
    check("mwrite_req", 32'(dmem_req), 32'd1);
    check("mwrite_we", 32'(dmem_we), 32'd1);
    check("mwrite_addr", 32'(dmem_addr), 32'd100);
    check("mwrite_wdata", 32'(dmem_wdata), 32'd5);
    check("program_dm_left", 32'(exp_q.size()), 32'd0);
`ifdef HACK_CPU_PERF_EN
    check("retired_count", retired, 32'd25);
`endif

    // abort the pending write with an asynchronous reset
    #2;
    reset = 1'b0;
    #1;
    check("abort_dmem_req", 32'(dmem_req), 32'd0);
    check("abort_imem_req", 32'(imem_req), 32'd0);
    check("abort_pc", 32'(pc), 32'd0);
`ifdef HACK_CPU_PERF_EN
    check("abort_retired", retired, 32'd0);
`endif
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    push_fetch(15'd0, 16'hFFFF);
    push_fetch(15'd1, 16'd2);
    push_fetch(15'd2, 16'd2);
    push_fetch(15'd3, 16'd2);
    push_dm(1'b1, 15'd100, 16'h0005, 8'd1);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    stray_ack = 1'b0;

    wait_n = 0;
    while ((fetch_q.size() != 0 || exp_q.size() != 0) && wait_n < 200) begin
      @(negedge clk);
      #1;
      wait_n++;
    end
    check("rerun_fetches_left", 32'(fetch_q.size()), 32'd0);
    check("rerun_dm_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    check("rerun_pc", 32'(pc), 32'd4);
    check("rerun_next_req", 32'(imem_req), 32'd1);
`ifdef HACK_CPU_PERF_EN
    check("rerun_retired", retired, 32'd4);
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
